// File: rtl/display_pkg.sv
// Shared types and constants for the seven-segment display scheduler.
// The BCD nibble helper is used by the double-dabble step.
package display_pkg;

    localparam int DIGIT_W   = 4;
    localparam int CONV_BITS = 14;
    localparam int BCD_W     = 4 * DIGIT_W;

    localparam logic [CONV_BITS-1:0] MAX_DISPLAY = 14'd9999;

    localparam logic SRC_A = 1'b0;
    localparam logic SRC_B = 1'b1;

    typedef enum logic [1:0] {
        IDLE,
        CONVERT,
        HOLD
    } state_t;

    function automatic logic [DIGIT_W-1:0] add3(input logic [DIGIT_W-1:0] d);
        return (d >= DIGIT_W'(5)) ? d + DIGIT_W'(3) : d;
    endfunction

endpackage

// File: rtl/bcd_dabble_step.sv
// One combinational double-dabble iteration: add 3 to every BCD nibble >= 5,
// then shift {bcd, operand} left by one bit.
module bcd_dabble_step
    import display_pkg::*;
(
    input  logic [BCD_W-1:0]     bcd_in,
    input  logic [CONV_BITS-1:0] operand_in,
    output logic [BCD_W-1:0]     bcd_out,
    output logic [CONV_BITS-1:0] operand_out
);

    localparam int W = BCD_W + CONV_BITS;

    logic [BCD_W-1:0] adj;
    logic [W-1:0]     shifted;

    always_comb begin
        adj = '0;
        for (int i = 0; i < 4; i++) begin
            adj[i*DIGIT_W +: DIGIT_W] = add3(bcd_in[i*DIGIT_W +: DIGIT_W]);
        end
    end

    // The adjusted top bit is shifted out; a valid BCD value never sets it.
    assign shifted     = {adj, operand_in} << 1;
    assign bcd_out     = shifted[W-1 -: BCD_W];
    assign operand_out = shifted[CONV_BITS-1:0];

endmodule

// File: rtl/display_scheduler.sv
// Round-robin arbiter for the shared 4-digit display: grants one requester,
// saturates its value to 9999, converts to BCD and holds it for a dwell time.
module display_scheduler
    import display_pkg::*;
#(
    parameter int HOLD_CYCLES = 50_000_000,
    parameter int HOLD_W      = 26
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 req_a,
    input  logic [31:0]          data_a,
    output logic                 ack_a,
    input  logic                 req_b,
    input  logic [31:0]          data_b,
    output logic                 ack_b,
    output logic [DIGIT_W-1:0]   ones,
    output logic [DIGIT_W-1:0]   tens,
    output logic [DIGIT_W-1:0]   hundreds,
    output logic [DIGIT_W-1:0]   thousands,
    output logic                 overflow,
    output logic                 source,
    output logic                 update,
    output logic                 busy
);

    // Handshake: req_x is a level request; data_x must stay stable while req_x
    // is high. ack_x pulses for one cycle when data_x has been captured; a
    // requester that keeps req_x high afterwards is simply arbitrated again.

    state_t                 state;
    logic [BCD_W-1:0]       bcd;
    logic [CONV_BITS-1:0]   operand;
    logic [3:0]             iter;
    logic                   pend_ovf;
    logic                   pend_src;
    logic                   last_grant;
    logic [HOLD_W-1:0]      hold_cnt;

    logic                   grant_b;
    logic [31:0]            grant_data;
    logic [BCD_W-1:0]       step_bcd;
    logic [CONV_BITS-1:0]   step_operand;

    always_comb begin
        grant_b    = req_b && (!req_a || (last_grant == SRC_A));
        grant_data = grant_b ? data_b : data_a;
    end

    bcd_dabble_step u_step (
        .bcd_in      (bcd),
        .operand_in  (operand),
        .bcd_out     (step_bcd),
        .operand_out (step_operand)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            state      <= IDLE;
            bcd        <= '0;
            operand    <= '0;
            iter       <= '0;
            pend_ovf   <= 1'b0;
            pend_src   <= SRC_A;
            last_grant <= SRC_B;
            hold_cnt   <= '0;
            ack_a      <= 1'b0;
            ack_b      <= 1'b0;
            ones       <= '0;
            tens       <= '0;
            hundreds   <= '0;
            thousands  <= '0;
            overflow   <= 1'b0;
            source     <= SRC_A;
            update     <= 1'b0;
            busy       <= 1'b0;
        end else begin
            ack_a  <= 1'b0;
            ack_b  <= 1'b0;
            update <= 1'b0;
            case (state)
                IDLE: begin
                    if (req_a || req_b) begin
                        ack_a      <= !grant_b;
                        ack_b      <= grant_b;
                        last_grant <= grant_b;
                        pend_src   <= grant_b;
                        if (grant_data > {{(32-CONV_BITS){1'b0}}, MAX_DISPLAY}) begin
                            operand  <= MAX_DISPLAY;
                            pend_ovf <= 1'b1;
                        end else begin
                            operand  <= grant_data[CONV_BITS-1:0];
                            pend_ovf <= 1'b0;
                        end
                        bcd   <= '0;
                        iter  <= '0;
                        busy  <= 1'b1;
                        state <= CONVERT;
                    end
                end
                CONVERT: begin
                    bcd     <= step_bcd;
                    operand <= step_operand;
                    iter    <= iter + 4'd1;
                    // Last iteration goes straight to the digit registers.
                    if (iter == 4'(CONV_BITS - 1)) begin
                        ones      <= step_bcd[0*DIGIT_W +: DIGIT_W];
                        tens      <= step_bcd[1*DIGIT_W +: DIGIT_W];
                        hundreds  <= step_bcd[2*DIGIT_W +: DIGIT_W];
                        thousands <= step_bcd[3*DIGIT_W +: DIGIT_W];
                        overflow  <= pend_ovf;
                        source    <= pend_src;
                        update    <= 1'b1;
                        hold_cnt  <= HOLD_W'(HOLD_CYCLES);
                        state     <= HOLD;
                    end
                end
                HOLD: begin
                    if (hold_cnt == '0) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end else begin
                        hold_cnt <= hold_cnt - HOLD_W'(1);
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_display_scheduler.sv
// Directed bench for display_scheduler: two instances (dwell 3 and dwell 0)
// share clock and reset; expected digits are hand-computed BCD constants.
module tb_display_scheduler;

    logic        clock;
    logic        reset;

    logic        req_a, req_b;
    logic [31:0] data_a, data_b;
    logic        ack_a, ack_b;
    logic [3:0]  ones, tens, hundreds, thousands;
    logic        overflow, source, update, busy;

    logic        req_a1, req_b1;
    logic [31:0] data_a1, data_b1;
    logic        ack_a1, ack_b1;
    logic [3:0]  ones1, tens1, hundreds1, thousands1;
    logic        overflow1, source1, update1, busy1;

    logic [15:0] st_bcd, st_bcd_out;
    logic [13:0] st_op, st_op_out;

    int vectors = 0;
    int fails   = 0;
    int viol    = 0;
    bit busy_prev = 1'b0;

    display_scheduler #(.HOLD_CYCLES(3), .HOLD_W(26)) dut (
        .clock(clock), .reset(reset),
        .req_a(req_a), .data_a(data_a), .ack_a(ack_a),
        .req_b(req_b), .data_b(data_b), .ack_b(ack_b),
        .ones(ones), .tens(tens), .hundreds(hundreds), .thousands(thousands),
        .overflow(overflow), .source(source), .update(update), .busy(busy)
    );

    display_scheduler #(.HOLD_CYCLES(0), .HOLD_W(26)) dut1 (
        .clock(clock), .reset(reset),
        .req_a(req_a1), .data_a(data_a1), .ack_a(ack_a1),
        .req_b(req_b1), .data_b(data_b1), .ack_b(ack_b1),
        .ones(ones1), .tens(tens1), .hundreds(hundreds1), .thousands(thousands1),
        .overflow(overflow1), .source(source1), .update(update1), .busy(busy1)
    );

    bcd_dabble_step u_step_chk (
        .bcd_in(st_bcd), .operand_in(st_op),
        .bcd_out(st_bcd_out), .operand_out(st_op_out)
    );

    wire [15:0] digits  = {thousands, hundreds, tens, ones};
    wire [15:0] digits1 = {thousands1, hundreds1, tens1, ones1};

    // clock / reset
    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #500_000;
        $display("FAIL watchdog: simulation did not finish, observed timeout required finish");
        $fatal(1, "watchdog");
    end

    // An ack may only follow a cycle in which the scheduler was idle.
    always @(negedge clock) begin
        if ((ack_a || ack_b) && busy_prev) viol++;
        busy_prev = busy;
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h required %0h", tag, obs, exp);
        end
    endtask

    function automatic bit sig(input int sel);
        case (sel)
            0:  return ack_a;
            1:  return ack_b;
            2:  return update;
            3:  return !busy;
            4:  return ack_a || ack_b;
            default: return 1'b0;
        endcase
    endfunction

    task automatic wait_sig(input int sel, input int limit, output int n);
        n = 0;
        do begin
            tick();
            n++;
        end while (!sig(sel) && n < limit);
    endtask

    // One full transaction on the dwell-3 instance, starting from IDLE.
    task automatic run(input bit use_b, input logic [31:0] d, input logic [15:0] exp_d,
                       input bit exp_ovf, input string tag);
        int n;
        if (use_b) begin data_b = d; req_b = 1'b1; end
        else       begin data_a = d; req_a = 1'b1; end
        tick();
        check({tag, "_ack"}, use_b ? ack_b : ack_a, 1'b1);
        req_a = 1'b0;
        req_b = 1'b0;
        wait_sig(2, 40, n);
        check({tag, "_latency"}, n, 14);
        check({tag, "_digits"}, digits, exp_d);
        check({tag, "_ovf"}, overflow, exp_ovf);
        check({tag, "_src"}, source, use_b);
        wait_sig(3, 40, n);
        check({tag, "_hold"}, n, 4);
    endtask

    initial begin
        int n;
        bit got_b;

        reset  = 1'b1;
        req_a  = 1'b0; req_b  = 1'b0; data_a  = '0; data_b  = '0;
        req_a1 = 1'b0; req_b1 = 1'b0; data_a1 = '0; data_b1 = '0;
        st_bcd = '0; st_op = '0;

        // step module: hand-computed single iterations
        #1;
        st_bcd = 16'h0005; st_op = 14'h0000; #1;
        check("step_add3", {st_bcd_out, 2'b00, st_op_out}, {16'h0010, 16'h0000});
        st_bcd = 16'h0000; st_op = 14'h2000; #1;
        check("step_msb", {st_bcd_out, 2'b00, st_op_out}, {16'h0001, 16'h0000});
        st_bcd = 16'h0049; st_op = 14'h2001; #1;
        check("step_49", {st_bcd_out, 2'b00, st_op_out}, {16'h0099, 16'h0002});

        tick();
        tick();
        check("reset_outputs",
              {ones, tens, hundreds, thousands, overflow, source, update, busy, ack_a, ack_b}, '0);
        reset = 1'b0;

        // 1. basic conversion
        run(1'b0, 32'd1234, 16'h1234, 1'b0, "t1_1234");
        check("t1_update_pulse", update, 1'b0);

        // 2. boundaries
        run(1'b0, 32'd0,         16'h0000, 1'b0, "t2_zero");
        run(1'b0, 32'd9999,      16'h9999, 1'b0, "t2_9999");
        run(1'b0, 32'd10000,     16'h9999, 1'b1, "t2_10000");
        run(1'b0, 32'hFFFF_FFFF, 16'h9999, 1'b1, "t2_max");

        // 3. simultaneous requests right after reset
        reset = 1'b1; tick(); reset = 1'b0;
        data_a = 32'd7; data_b = 32'd42; req_a = 1'b1; req_b = 1'b1;
        tick();
        check("t3_ack_a", {ack_a, ack_b}, 2'b10);
        req_a = 1'b0;
        wait_sig(2, 40, n);
        check("t3_a_latency", n, 14);
        check("t3_a_digits", digits, 16'h0007);
        check("t3_a_src", source, 1'b0);
        wait_sig(1, 40, n);
        check("t3_b_grant_offset", n, 5);
        req_b = 1'b0;
        wait_sig(2, 40, n);
        check("t3_b_latency", n, 14);
        check("t3_b_digits", digits, 16'h0042);
        check("t3_b_src", source, 1'b1);
        wait_sig(3, 40, n);

        // 4. both held high: grants alternate starting with A
        data_a = 32'd1111; data_b = 32'd2222; req_a = 1'b1; req_b = 1'b1;
        for (int i = 0; i < 4; i++) begin
            wait_sig(4, 40, n);
            got_b = ack_b;
            check($sformatf("t4_grant%0d_owner", i), got_b, i % 2);
            check($sformatf("t4_grant%0d_gap", i), n, (i == 0) ? 1 : 19);
        end
        req_a = 1'b0; req_b = 1'b0;
        wait_sig(3, 60, n);
        check("t4_drain", n, 18);
        check("t4_digits", digits, 16'h2222);
        check("t4_src", source, 1'b1);
        check("t4_ack_while_busy", viol, 0);

        // 5. reset during iteration 7
        data_a = 32'd5678; req_a = 1'b1;
        tick();
        check("t5_ack", ack_a, 1'b1);
        req_a = 1'b0;
        repeat (6) tick();
        reset = 1'b1;
        tick();
        check("t5_reset_outputs",
              {ones, tens, hundreds, thousands, overflow, source, update, busy, ack_a, ack_b}, '0);
        reset = 1'b0;
        n = 0;
        repeat (20) begin
            tick();
            if (update) n++;
        end
        check("t5_no_update", n, 0);
        run(1'b1, 32'd5678, 16'h5678, 1'b0, "t5_b_5678");

        // 6. zero dwell, B raised during A's conversion
        reset = 1'b1; tick(); reset = 1'b0;
        data_a1 = 32'd321; req_a1 = 1'b1;
        tick();
        check("t6_ack_a", ack_a1, 1'b1);
        req_a1 = 1'b0;
        repeat (3) tick();
        data_b1 = 32'd654; req_b1 = 1'b1;
        n = 0;
        while (!update1 && n < 40) begin
            tick();
            n++;
            if (ack_b1) check("t6_early_ack_b", ack_b1, 1'b0);
        end
        check("t6_a_latency", n, 11);
        check("t6_a_digits", digits1, 16'h0321);
        n = 0;
        while (!ack_b1 && n < 40) begin
            tick();
            n++;
        end
        check("t6_b_grant_offset", n, 2);
        check("t6_digits_at_grant", digits1, 16'h0321);
        req_b1 = 1'b0;
        n = 0;
        while (!update1 && n < 40) begin
            tick();
            n++;
            if (!update1) check("t6_digits_stable", digits1, 16'h0321);
        end
        check("t6_b_latency", n, 14);
        check("t6_b_digits", digits1, 16'h0654);
        check("t6_b_src", source1, 1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
        $finish;
    end

endmodule
